// File: rtl/machinaut_systolic_pe_if.sv
// machinaut_systolic_pe_if: TinyTapeout user-module pin bundle for one systolic PE
interface machinaut_systolic_pe_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    modport master(output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave(input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/machinaut_systolic_pe.sv
// machinaut_systolic_pe: systolic MAC element forwarding row/col nibbles and accumulating their dot product
module machinaut_systolic_pe (
    input logic clk,
    input logic rst,
    machinaut_systolic_pe_if.slave bus
);
    logic [3:0] row_in, col_in, row_q, col_q;
    logic row_ctrl_q, col_ctrl_q, prev_both, both;
    logic [1:0] rd_ptr;
    logic [7:0] prod8;
    logic [15:0] acc, prod, acc_shift;
    logic unused_bits;
    assign row_in = bus.ui_in[3:0];
    assign col_in = bus.ui_in[7:4];
    assign both = bus.uio_in[3] & bus.uio_in[2];
    assign prod8 = row_in * col_in;
    assign prod = {8'd0, prod8};
    assign acc_shift = acc >> {rd_ptr, 2'b00};
    assign unused_bits = ^{bus.uio_in[7:4], bus.uio_in[1:0]};
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
            row_ctrl_q <= 1'b0;
            col_ctrl_q <= 1'b0;
            prev_both <= 1'b0;
            rd_ptr <= '0;
            acc <= '0;
        end else if (bus.ena) begin
            row_q <= row_in;
            col_q <= col_in;
            row_ctrl_q <= bus.uio_in[2];
            col_ctrl_q <= bus.uio_in[3];
            prev_both <= both;
            rd_ptr <= rd_ptr + 2'd1;
            // a run's first valid cycle replaces the old result instead of adding to it
            if (both) acc <= prev_both ? acc + prod : prod;
        end
    end
    assign bus.uo_out = {col_q, row_q};
    assign bus.uio_out = {acc_shift[3:0], 2'b00, col_ctrl_q, row_ctrl_q};
    assign bus.uio_oe = 8'hF3;
endmodule

// File: tb/tb_machinaut_systolic_pe.sv
// tb_machinaut_systolic_pe: scoreboard bench for a single PE and a 2x2 tiled array
module tb_machinaut_systolic_pe;
    logic clk = 1'b0;
    logic rst;
    int cyc = 0;
    int rd = 0;
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    machinaut_systolic_pe_if m();
    machinaut_systolic_pe_if t00();
    machinaut_systolic_pe_if t01();
    machinaut_systolic_pe_if t10();
    machinaut_systolic_pe_if t11();

    machinaut_systolic_pe dut (.clk(clk), .rst(rst), .bus(m));
    machinaut_systolic_pe pe00 (.clk(clk), .rst(rst), .bus(t00));
    machinaut_systolic_pe pe01 (.clk(clk), .rst(rst), .bus(t01));
    machinaut_systolic_pe pe10 (.clk(clk), .rst(rst), .bus(t10));
    machinaut_systolic_pe pe11 (.clk(clk), .rst(rst), .bus(t11));

    logic [3:0] r0d, r1d, c0d, c1d;
    logic r0v, r1v, c0v, c1v;
    assign t00.ena = m.ena;
    assign t01.ena = m.ena;
    assign t10.ena = m.ena;
    assign t11.ena = m.ena;
    assign t00.ui_in = {c0d, r0d};
    assign t00.uio_in = {4'h0, c0v, r0v, 2'b00};
    assign t01.ui_in = {c1d, t00.uo_out[3:0]};
    assign t01.uio_in = {4'h0, c1v, t00.uio_out[0], 2'b00};
    assign t10.ui_in = {t00.uo_out[7:4], r1d};
    assign t10.uio_in = {4'h0, t00.uio_out[1], r1v, 2'b00};
    assign t11.ui_in = {t01.uo_out[7:4], t10.uo_out[3:0]};
    assign t11.uio_in = {4'h0, t01.uio_out[1], t10.uio_out[0], 2'b00};

    typedef struct {
        int cyc;
        int id;
        logic [7:0] uo;
        logic [7:0] muo;
        logic [7:0] uio;
        logic [7:0] muio;
        string tag;
    } exp_t;
    exp_t q[$];
    exp_t e;
    logic [7:0] ao, aio, aoe;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            case (e.id)
                0: begin ao = m.uo_out; aio = m.uio_out; aoe = m.uio_oe; end
                1: begin ao = t00.uo_out; aio = t00.uio_out; aoe = t00.uio_oe; end
                2: begin ao = t01.uo_out; aio = t01.uio_out; aoe = t01.uio_oe; end
                3: begin ao = t10.uo_out; aio = t10.uio_out; aoe = t10.uio_oe; end
                default: begin ao = t11.uo_out; aio = t11.uio_out; aoe = t11.uio_oe; end
            endcase
            tests++;
            if ((ao & e.muo) !== (e.uo & e.muo) || (aio & e.muio) !== (e.uio & e.muio) || aoe !== 8'hF3) begin
                fails++;
                $display("FAIL %s cyc=%0d pe=%0d: uo_out=%h uio_out=%h uio_oe=%h, required uo_out=%h/%h uio_out=%h/%h uio_oe=f3",
                         e.tag, cyc, e.id, ao, aio, aoe, e.uo, e.muo, e.uio, e.muio);
            end
        end
    end

    task automatic drive(input logic [3:0] row, input logic [3:0] col, input logic rc, input logic cc);
        m.ui_in = {col, row};
        m.uio_in = {4'($urandom), cc, rc, 2'($urandom)};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) rd = 0;
        else if (m.ena) rd = (rd + 1) % 4;
    endtask

    task automatic push(input int id, input logic [7:0] uo, input logic [7:0] muo,
                        input logic [7:0] uio, input logic [7:0] muio, input string tag);
        exp_t x;
        x.cyc = cyc; x.id = id; x.uo = uo; x.muo = muo; x.uio = uio; x.muio = muio; x.tag = tag;
        q.push_back(x);
    endtask

    function automatic logic [3:0] nib(input logic [15:0] v);
        logic [15:0] s;
        s = v >> (4 * rd);
        return s[3:0];
    endfunction

    // one enabled cycle on the main PE, checking forwarded data and the acc nibble after the edge
    task automatic mac(input logic [3:0] row, input logic [3:0] col, input logic rc, input logic cc,
                       input logic [15:0] acc, input string tag);
        drive(row, col, rc, cc);
        tick();
        push(0, {col, row}, 8'hFF, {nib(acc), 2'b00, cc, rc}, 8'hFF, tag);
    endtask

    task automatic read_acc(input logic [15:0] acc, input string tag);
        for (int i = 0; i < 4; i++) mac(4'h0, 4'h0, 1'b0, 1'b0, acc, tag);
    endtask

    int a[2][2] = '{'{1, 2}, '{3, 4}};
    int b[2][2] = '{'{5, 6}, '{7, 8}};
    logic [15:0] c[4] = '{16'd19, 16'd22, 16'd43, 16'd50};

    initial begin
        r0d = 0; r1d = 0; c0d = 0; c1d = 0;
        r0v = 0; r1v = 0; c0v = 0; c1v = 0;
        m.ena = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
            tick();
            push(0, 8'h00, 8'hFF, 8'h00, 8'hFF, "reset");
        end
        rst = 1'b0;
        // dot product 12+30+225
        mac(4'd3, 4'd4, 1'b1, 1'b1, 16'd12, "dot1");
        mac(4'd5, 4'd6, 1'b1, 1'b1, 16'd42, "dot2");
        mac(4'd15, 4'd15, 1'b1, 1'b1, 16'd267, "dot3");
        read_acc(16'h010B, "dot_read");
        // pass-through 0xA5 with col_ctrl only, then freeze
        mac(4'h5, 4'hA, 1'b0, 1'b1, 16'h010B, "pass");
        m.ena = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(4'h3, 4'hC, 1'b1, 1'b1);
            tick();
            push(0, 8'hA5, 8'hFF, {nib(16'h010B), 4'b0010}, 8'hFF, "hold");
        end
        m.ena = 1'b1;
        mac(4'd2, 4'd7, 1'b1, 1'b1, 16'd14, "restart");
        read_acc(16'd14, "restart_read");
        mac(4'd1, 4'd1, 1'b1, 1'b1, 16'd1, "cont1");
        mac(4'd2, 4'd2, 1'b1, 1'b1, 16'd5, "cont2");
        mac(4'd9, 4'd9, 1'b1, 1'b0, 16'd5, "row_only");
        mac(4'd9, 4'd9, 1'b0, 1'b1, 16'd5, "col_only");
        mac(4'd3, 4'd3, 1'b1, 1'b1, 16'd9, "load_after_gap");
        read_acc(16'd9, "gap_read");
        for (int k = 1; k <= 292; k++) mac(4'd15, 4'd15, 1'b1, 1'b1, 16'(k * 225), "wrap_run");
        read_acc(16'h00A4, "wrap_read");
        mac(4'd4, 4'd4, 1'b1, 1'b1, 16'd16, "pre_rst1");
        mac(4'd4, 4'd4, 1'b1, 1'b1, 16'd32, "pre_rst2");
        rst = 1'b1;
        drive(4'd4, 4'd4, 1'b1, 1'b1);
        tick();
        push(0, 8'h00, 8'hFF, 8'h00, 8'hFF, "mid_reset");
        rst = 1'b0;
        mac(4'd2, 4'd3, 1'b1, 1'b1, 16'd6, "post_rst_load");
        read_acc(16'd6, "post_rst_read");
        // skewed 2x2 feed: row i lags i cycles, column j lags j cycles
        for (int t = 0; t < 5; t++) begin
            r0v = (t < 2);         r0d = r0v ? 4'(a[0][t]) : 4'h0;
            r1v = (t >= 1 && t < 3); r1d = r1v ? 4'(a[1][t-1]) : 4'h0;
            c0v = (t < 2);         c0d = c0v ? 4'(b[t][0]) : 4'h0;
            c1v = (t >= 1 && t < 3); c1d = c1v ? 4'(b[t-1][1]) : 4'h0;
            drive(4'h0, 4'h0, 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            drive(4'h0, 4'h0, 1'b0, 1'b0);
            tick();
            if (i >= 2)
                for (int p = 0; p < 4; p++) push(p + 1, 8'h00, 8'h00, {nib(c[p]), 4'h0}, 8'hF0, "tile");
        end
        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        if (q.size() > 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
